// File: rtl/hzrd_fwd_ctrl_pkg.sv
// rtl/hzrd_fwd_ctrl_pkg.sv - shared forward-select encodings and width helper
package hzrd_fwd_ctrl_pkg;

  localparam int SEL_REGFILE = 0;
  localparam int SEL_MEM     = 1;

  // Width of a forward select / stage index; never below one bit.
  function automatic int sel_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/hzrd_src_match.sv
// rtl/hzrd_src_match.sv - compares one source operand against every shadow entry
module hzrd_src_match
  import hzrd_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  localparam int KW       = sel_w(FWD_DEPTH)
) (
  input  logic [REG_AW-1:0]           i_rs_addr,
  input  logic                        i_rs_used,
  input  logic [FWD_DEPTH-1:0]        i_ent_valid,
  input  logic [FWD_DEPTH-1:0]        i_ent_wen,
  input  logic [FWD_DEPTH-1:0]        i_ent_is_load,
  input  logic [FWD_DEPTH*REG_AW-1:0] i_ent_waddr,
  output logic                        o_hit,
  output logic                        o_load_hit,
  output logic [KW-1:0]               o_k
);

  logic [FWD_DEPTH-1:0] w_match;

  always_comb begin
    for (int k = 0; k < FWD_DEPTH; k++) begin
      w_match[k] = i_rs_used & i_ent_valid[k] & i_ent_wen[k] &
                   (i_ent_waddr[k*REG_AW +: REG_AW] == i_rs_addr) & (i_rs_addr != '0);
    end
  end

  // Scan oldest to youngest so the lowest matching k is left in o_k.
  always_comb begin
    o_hit      = |w_match;
    o_load_hit = 1'b0;
    o_k        = '0;
    for (int k = FWD_DEPTH-1; k >= 0; k--) begin
      if (w_match[k]) o_k = KW'(k);
    end
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (w_match[k] && i_ent_is_load[k]) o_load_hit = 1'b1;
    end
  end

endmodule

// File: rtl/hzrd_fwd_ctrl.sv
// rtl/hzrd_fwd_ctrl.sv - hazard detection and forward-select control for the integer pipe
module hzrd_fwd_ctrl
  import hzrd_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = sel_w(FWD_DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] i_id_rs_addr,
  input  logic [NUM_SRC-1:0]        i_id_rs_used,
  input  logic                      i_id_rd_wen,
  input  logic [REG_AW-1:0]         i_id_rd_waddr,
  input  logic                      i_id_is_load,
  input  logic                      i_flush,
  input  logic                      i_ext_stall,
  output logic                      o_if_id_halt,
  output logic                      o_id_ex_halt,
  output logic                      o_id_ex_bubble,
  output logic [NUM_SRC*SEL_W-1:0]  o_fwd_sel,
  output logic [CNT_W-1:0]          o_stall_cnt
);

  localparam logic [SEL_W-1:0] K_FWD_MAX = SEL_W'(FWD_DEPTH-2);

  // Shadow pipe: entry 0 (EX) sits at the LSB end of each vector.
  logic [FWD_DEPTH-1:0]        r_valid;
  logic [FWD_DEPTH-1:0]        r_wen;
  logic [FWD_DEPTH-1:0]        r_is_load;
  logic [FWD_DEPTH*REG_AW-1:0] r_waddr;
  logic [NUM_SRC*SEL_W-1:0]    r_fwd_sel;
  logic [CNT_W-1:0]            r_stall_cnt;

  logic [NUM_SRC-1:0]          w_hit;
  logic [NUM_SRC-1:0]          w_load_hit;
  logic [NUM_SRC*SEL_W-1:0]    w_k;
  logic [NUM_SRC*SEL_W-1:0]    w_sel_next;
  logic                        w_load_use;
  logic                        w_issue;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    hzrd_src_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT)
    ) u_match (
      .i_rs_addr     (i_id_rs_addr[j*REG_AW +: REG_AW]),
      .i_rs_used     (i_id_rs_used[j]),
      .i_ent_valid   (r_valid),
      .i_ent_wen     (r_wen),
      .i_ent_is_load (r_is_load),
      .i_ent_waddr   (r_waddr),
      .o_hit         (w_hit[j]),
      .o_load_hit    (w_load_hit[j]),
      .o_k           (w_k[j*SEL_W +: SEL_W])
    );
  end

  assign w_load_use = i_id_valid & ~i_flush & (|w_load_hit);
  assign w_issue    = i_id_valid & ~i_flush & ~w_load_use;

  // The oldest tracked stage has already written the regfile, so it needs no bypass.
  always_comb begin
    w_sel_next = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      w_sel_next[j*SEL_W +: SEL_W] = SEL_W'(SEL_REGFILE);
      if (w_issue && w_hit[j] && (w_k[j*SEL_W +: SEL_W] <= K_FWD_MAX)) begin
        w_sel_next[j*SEL_W +: SEL_W] = w_k[j*SEL_W +: SEL_W] + SEL_W'(SEL_MEM);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= '0;
      r_wen       <= '0;
      r_is_load   <= '0;
      r_waddr     <= '0;
      r_fwd_sel   <= '0;
      r_stall_cnt <= '0;
    end else if (!i_ext_stall) begin
      r_valid     <= {r_valid[FWD_DEPTH-2:0], w_issue};
      r_wen       <= {r_wen[FWD_DEPTH-2:0], i_id_rd_wen};
      r_is_load   <= {r_is_load[FWD_DEPTH-2:0], i_id_is_load};
      r_waddr     <= {r_waddr[(FWD_DEPTH-1)*REG_AW-1:0], i_id_rd_waddr};
      r_fwd_sel   <= w_sel_next;
      if (w_load_use && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_id_ex_halt   = i_ext_stall;
  assign o_if_id_halt   = i_ext_stall | w_load_use;
  assign o_id_ex_bubble = ~i_ext_stall & (w_load_use | i_flush);
  assign o_fwd_sel      = r_fwd_sel;
  assign o_stall_cnt    = r_stall_cnt;

endmodule
